// File: rtl/puntaje_pkg.sv
// puntaje_pkg: shared constants and FSM state type for the score-update controller
package puntaje_pkg;
  localparam logic [2:0] PRESENTE_START = 3'd1;
  localparam logic [2:0] PRESENTE_PLAY  = 3'd2;
  localparam logic [2:0] PRESENTE_OVER  = 3'd4;
  localparam int W_PTS_DEF = 9;
  typedef enum logic [1:0] {IDLE, APPLY, WAIT} fsm_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
//   req: request levels; ptr: highest-priority index
//   gnt: one-hot grant; idx: granted index; any: some request present
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             any
);
  logic [IW-1:0] w_j;
  // walk offsets from farthest to nearest so the nearest request to ptr wins
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    w_j = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_j = IW'((int'(ptr) + k) % N_REQ);
      if (req[w_j]) begin
        gnt = '0;
        gnt[w_j] = 1'b1;
        idx = w_j;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/puntaje_ctrl.sv
// puntaje_ctrl: arbitrated saturating score updates with clear-on-start and session record
//   clk_puntaje/rst_n: clock, asynchronous active-low reset
//   presente: game FSM state; req/amt/sub: per-requester update requests
//   ack: one-hot completion pulse; puntos: score; record: best end-of-game score
//   sat: clipped-update pulse; busy: update in progress
module puntaje_ctrl
  import puntaje_pkg::*;
#(
  parameter int         N_REQ    = 4,
  parameter int         W_PTS    = W_PTS_DEF,
  parameter int         W_AMT    = 4,
  parameter logic [2:0] ST_START = PRESENTE_START,
  parameter logic [2:0] ST_PLAY  = PRESENTE_PLAY,
  parameter logic [2:0] ST_OVER  = PRESENTE_OVER
) (
  input  logic                   clk_puntaje,
  input  logic                   rst_n,
  input  logic [2:0]             presente,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*W_AMT-1:0] amt,
  input  logic [N_REQ-1:0]       sub,
  output logic [N_REQ-1:0]       ack,
  output logic [W_PTS-1:0]       puntos,
  output logic [W_PTS-1:0]       record,
  output logic                   sat,
  output logic                   busy
);
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  fsm_t             r_state;
  logic [IW-1:0]    r_ptr, r_idx, w_idx;
  logic [N_REQ-1:0] r_gnt, w_gnt;
  logic [W_AMT-1:0] r_amt;
  logic             r_sub;
  logic [2:0]       r_prev;
  logic             w_any, w_clr, w_over, w_add_sat, w_sub_sat, w_clip;
  logic [W_PTS:0]   w_amt_x, w_sum;
  logic [W_PTS-1:0] w_new;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req(req),
    .ptr(r_ptr),
    .gnt(w_gnt),
    .idx(w_idx),
    .any(w_any)
  );

  // arithmetic one bit wider than the score so both overflow and underflow are visible
  assign w_amt_x   = (W_PTS + 1)'(r_amt);
  assign w_sum     = {1'b0, puntos} + w_amt_x;
  assign w_add_sat = w_sum[W_PTS];
  assign w_sub_sat = w_amt_x > {1'b0, puntos};
  assign w_new     = r_sub ? (w_sub_sat ? '0 : puntos - W_PTS'(r_amt))
                           : (w_add_sat ? '1 : w_sum[W_PTS-1:0]);
  assign w_clip    = r_sub ? w_sub_sat : w_add_sat;
  assign w_clr     = presente == ST_START && r_prev != ST_START;
  assign w_over    = presente == ST_OVER && r_prev != ST_OVER;

  always_ff @(posedge clk_puntaje or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_gnt   <= '0;
      r_amt   <= '0;
      r_sub   <= 1'b0;
      r_prev  <= '0;
      puntos  <= '0;
      record  <= '0;
      ack     <= '0;
      sat     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      r_prev <= presente;
      ack    <= '0;
      sat    <= 1'b0;
      if (w_over && puntos > record) record <= puntos;
      if (w_clr) puntos <= '0;
      case (r_state)
        IDLE: if (presente == ST_PLAY && w_any) begin
          r_idx   <= w_idx;
          r_gnt   <= w_gnt;
          r_amt   <= amt[int'(w_idx)*W_AMT +: W_AMT];
          r_sub   <= sub[w_idx];
          r_state <= APPLY;
          busy    <= 1'b1;
        end
        APPLY: begin
          // a clear on the same edge wins; the requester is still acknowledged
          if (!w_clr) begin
            puntos <= w_new;
            sat    <= w_clip;
          end
          ack     <= r_gnt;
          r_ptr   <= r_idx == IW'(N_REQ - 1) ? '0 : r_idx + 1'b1;
          r_state <= WAIT;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_puntaje_ctrl.sv
// tb_puntaje_ctrl: scoreboard bench for puntaje_ctrl
module tb_puntaje_ctrl;
  import puntaje_pkg::*;
  localparam int N = 4, WP = 9, WA = 4;
  logic clk_puntaje = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] presente = '0;
  logic [N-1:0] req = '0, sub = '0;
  logic [N*WA-1:0] amt = '0;
  logic [N-1:0] ack;
  logic [WP-1:0] puntos, record;
  logic sat, busy;
  typedef struct {
    logic [N-1:0]  ack;
    logic [WP-1:0] pts;
    logic          sat;
  } exp_t;
  exp_t sb[$];
  int acq[$];
  int n_cmp = 0, n_err = 0, cyc = 0, ack_cyc = 0, n_ack = 0, t0 = 0, score = 0, best = 0;

  puntaje_ctrl dut (
    .clk_puntaje(clk_puntaje),
    .rst_n(rst_n),
    .presente(presente),
    .req(req),
    .amt(amt),
    .sub(sub),
    .ack(ack),
    .puntos(puntos),
    .record(record),
    .sat(sat),
    .busy(busy)
  );

  always #5 clk_puntaje = ~clk_puntaje;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk_puntaje);
    cyc++;
    if (ack !== '0) begin
      ack_cyc = cyc;
      n_ack++;
      acq.push_back(cyc);
      if (sb.size() == 0) chk("spurious_ack", 32'(ack), 32'(0));
      else begin
        e = sb.pop_front();
        chk("ack", 32'(ack), 32'(e.ack));
        chk("puntos", 32'(puntos), 32'(e.pts));
        chk("sat", 32'(sat), 32'(e.sat));
        req = req & ~ack;
      end
    end
  endtask

  task automatic push(input int i, input int a, input bit s);
    exp_t e;
    int nv;
    bit c;
    if (s) begin
      c  = a > score;
      nv = c ? 0 : score - a;
    end else begin
      c  = score + a > 511;
      nv = c ? 511 : score + a;
    end
    score = nv;
    e.ack = N'(1) << i;
    e.pts = WP'(nv);
    e.sat = c;
    sb.push_back(e);
    req = req | (N'(1) << i);
    sub = s ? (sub | (N'(1) << i)) : (sub & ~(N'(1) << i));
    amt[i*WA +: WA] = WA'(a);
  endtask

  task automatic drain(input int lat);
    int n = 0;
    while (sb.size() > 0 && n < 40) begin
      step();
      n++;
    end
    if (sb.size() > 0) begin
      chk("timeout", 32'(sb.size()), 32'(0));
      sb.delete();
    end
    if (lat > 0) chk("latency", 32'(ack_cyc - t0), 32'(lat));
  endtask

  task automatic one(input int i, input int a, input bit s);
    step();
    t0 = cyc;
    push(i, a, s);
    drain(2);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    sub = '0;
    amt = '0;
    presente = '0;
    step();
    step();
    rst_n = 1'b1;
    score = 0;
    best = 0;
    sb.delete();
    step();
  endtask

  task automatic start_play();
    presente = PRESENTE_START;
    step();
    score = 0;
    presente = PRESENTE_PLAY;
    step();
  endtask

  task automatic game_over();
    step();
    presente = PRESENTE_OVER;
    step();
    if (score > best) best = score;
    chk("record", 32'(record), 32'(best));
  endtask

  initial begin
    exp_t e;
    int a0;
    do_reset();
    chk("rst_puntos", 32'(puntos), 32'(0));
    chk("rst_record", 32'(record), 32'(0));
    chk("rst_ack", 32'(ack), 32'(0));
    chk("rst_sat", 32'(sat), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));

    start_play();
    one(1, 5, 1'b0);
    chk("score_5", 32'(puntos), 32'(5));

    do_reset();
    start_play();
    acq.delete();
    for (int i = 0; i < N; i++) push(i, i + 1, 1'b0);
    drain(0);
    chk("n_acks_batch", 32'(acq.size()), 32'(4));
    for (int i = 1; i < acq.size(); i++) chk("ack_gap", 32'(acq[i] - acq[i-1]), 32'(3));
    chk("score_10", 32'(puntos), 32'(10));
    step();
    push(0, 0, 1'b0);
    push(3, 7, 1'b0);
    drain(0);
    chk("score_17", 32'(puntos), 32'(score));

    do_reset();
    start_play();
    for (int j = 0; j < 33; j++) one(0, 15, 1'b0);
    one(0, 13, 1'b0);
    chk("score_508", 32'(puntos), 32'(508));
    one(1, 15, 1'b0);
    chk("score_511", 32'(puntos), 32'(511));
    step();
    chk("sat_one_cycle", 32'(sat), 32'(0));

    do_reset();
    start_play();
    one(2, 3, 1'b0);
    one(2, 7, 1'b1);
    chk("score_floor", 32'(puntos), 32'(0));
    one(3, 8, 1'b0);
    one(1, 3, 1'b1);
    chk("score_sub", 32'(puntos), 32'(5));

    step();
    presente = '0;
    step();
    a0 = n_ack;
    req[2] = 1'b1;
    amt[2*WA +: WA] = 4'd6;
    sub[2] = 1'b0;
    for (int j = 0; j < 20; j++) step();
    chk("no_ack_idle", 32'(n_ack - a0), 32'(0));
    chk("hold_puntos", 32'(puntos), 32'(score));
    push(2, 6, 1'b0);
    t0 = cyc;
    presente = PRESENTE_PLAY;
    drain(2);

    do_reset();
    start_play();
    for (int j = 0; j < 13; j++) one(0, 15, 1'b0);
    one(0, 5, 1'b0);
    game_over();
    chk("record_200", 32'(record), 32'(200));
    presente = PRESENTE_START;
    step();
    score = 0;
    chk("clear_start", 32'(puntos), 32'(0));
    presente = PRESENTE_PLAY;
    step();
    for (int j = 0; j < 10; j++) one(1, 15, 1'b0);
    game_over();
    chk("record_kept", 32'(record), 32'(200));
    start_play();
    one(0, 9, 1'b0);
    step();
    push(0, 4, 1'b0);
    e = sb.pop_back();
    e.pts = '0;
    sb.push_back(e);
    score = 0;
    step();
    presente = PRESENTE_START;
    step();
    chk("clear_apply", 32'(puntos), 32'(0));
    presente = PRESENTE_PLAY;
    step();
    one(1, 5, 1'b0);

    step();
    req[3] = 1'b1;
    amt[3*WA +: WA] = 4'd2;
    sub[3] = 1'b0;
    step();
    chk("busy_apply", 32'(busy), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("async_puntos", 32'(puntos), 32'(0));
    chk("async_record", 32'(record), 32'(0));
    chk("async_busy", 32'(busy), 32'(0));
    chk("async_ack", 32'(ack), 32'(0));
    a0 = n_ack;
    req = '0;
    step();
    step();
    chk("no_ack_reset", 32'(n_ack - a0), 32'(0));
    rst_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
